nlm_blend_out: RTL
==================

// Module: nlm_blend_out
// PURPOSE
//   Output stage directly downstream of the NLM core. Blends the original pixel with the
//   NLM-denoised pixel using a per-frame strength alpha (0..16, in 1/16 steps).
//   Re-times valid/line/frame sync to the blended data and checks frame geometry
//   against IMAGE_WIDTH x IMAGE_HEIGHT.
// PARAMETERS
//   DATA_WIDTH    12    pixel bit width
//   IMAGE_WIDTH   1920  valid pixels per line
//   IMAGE_HEIGHT  1080  lines per frame
//   CNT_WIDTH     12    width of column/row counters; must hold IMAGE_WIDTH and IMAGE_HEIGHT
// PORTS
//   clk             in   1           clock
//   rst_n           in   1           asynchronous active-low reset
//   valid_i         in   1           input pixel valid
//   frame_sync_i    in   1           first pixel of frame; qualified by valid_i
//   line_sync_i     in   1           first pixel of line; qualified by valid_i; also high with frame_sync_i
//   pix_original_i  in   DATA_WIDTH  unfiltered pixel
//   pix_denoise_i   in   DATA_WIDTH  NLM-filtered pixel, same position as pix_original_i
//   alpha_i         in   5           blend strength; values >16 are clamped to 16
//   pix_o           out  DATA_WIDTH  blended pixel
//   valid_o         out  1           output valid
//   line_sync_o     out  1           line_sync_i aligned to pix_o
//   frame_sync_o    out  1           frame_sync_i aligned to pix_o
//   geom_err_o      out  1           sticky geometry-error flag
// BEHAVIOUR
//   - Reset: pix_o=0, valid_o=0, line_sync_o=0, frame_sync_o=0, geom_err_o=0.
//     Reset also clears: counters, pipeline regs, alpha_act=16, first_frame=1.
//   - Reset mid-frame: state is dropped. Checking resumes at the next frame_sync_i.
//   - alpha_act (shadow) loads min(alpha_i,16) only on a valid_i & frame_sync_i cycle,
//     and that same pixel uses the new value. alpha_i changes mid-frame have no effect.
//   - Pipeline, LAT=2 cycles:
//       S1 registers p_o = orig*(16-a) and p_d = den*a, each DATA_WIDTH+5 bits.
//       S2 registers pix_o = (p_o + p_d + 8) >> 4, sum DATA_WIDTH+6 bits.
//     The result never exceeds max(orig,den), so no saturation logic is needed.
//       a=0  -> pix_o = orig exactly;  a=16 -> pix_o = den exactly.
//   - Data regs advance only when valid_i=1; they hold when valid_i=0.
//     valid_o/line_sync_o/frame_sync_o are valid_i/line_sync_i&valid_i/frame_sync_i&valid_i
//     each delayed LAT cycles. Syncs seen while valid_i=0 are ignored.
//     Bubbles are passed through unchanged (no compaction).
//   - col counts valid pixels in the current line; row counts lines in the current frame.
//   - On valid line_sync_i (not first_frame):
//       if col != IMAGE_WIDTH -> geom_err_o <= 1.
//     Then col <= 1 and row <= row+1 (row <= 1 on frame_sync_i).
//   - On valid frame_sync_i (not first_frame):
//       if row != IMAGE_HEIGHT or col != IMAGE_WIDTH -> geom_err_o <= 1.
//     Then first_frame <= 0.
//   - The first frame after reset is only checked from its own frame_sync_i onward.
//     Pixels before the first frame_sync_i are blended with alpha_act=16 and never counted.
//   - col/row saturate at all-ones and do not wrap.
//   - geom_err_o is sticky and is cleared only by rst_n.
// CONFIGURATION
//   NLM_BLEND_DELTA_CLAMP_EN defined:
//     - Adds input max_delta_i [DATA_WIDTH-1:0].
//     - Adds stage S0: den' = clamp(den, orig-max_delta_i, orig+max_delta_i), saturated to
//       [0, 2^DATA_WIDTH-1]. den' is used in place of den.
//     - LAT=3. Syncs and valid are delayed 3 cycles.
//   NLM_BLEND_DELTA_CLAMP_EN undefined:
//     - No max_delta_i port; den is used unmodified; LAT=2.
// TESTING
//   1 Reset release, then orig=100, den=200, alpha_i=8 with frame_sync_i
//     -> 2 cycles later pix_o=150, valid_o=1, frame_sync_o=1 and line_sync_o=1.
//   2 alpha_i=0 then 16 (each applied from a frame start), orig=4095, den=0
//     -> pix_o=4095, then pix_o=0. alpha_i=31 -> behaves as 16.
//   3 alpha_i changes 4->12 mid-frame -> that frame keeps alpha 4;
//     the new value applies from the next frame_sync_i pixel.
//   4 Two full 8x4 frames (IMAGE_WIDTH=8, IMAGE_HEIGHT=4) with random valid_i bubbles
//     -> geom_err_o stays 0; pix_o/valid_o match the reference model; bubbles are preserved.
//   5 A 7-pixel line inside frame 2 -> geom_err_o=1 from the next line_sync_i and stays 1
//     through frame 3. Assert rst_n mid-frame -> all outputs 0 and geom_err_o=0.
//   6 Macro defined, max_delta_i=10, orig=100, den=200, alpha_i=16
//     -> pix_o=110 with LAT=3. orig=5, den=0, max_delta_i=10, alpha_i=16 -> pix_o=0.

Source files
------------

// File: rtl/nlm_blend_out.sv
// nlm_blend_out: output stage behind the NLM core.
// Blends the original and denoised pixels with a per-frame strength alpha in 1/16 steps.
// Re-times valid and the line/frame syncs to the blended data.
// Also checks frame geometry against IMAGE_WIDTH x IMAGE_HEIGHT.
// Optional feature macro: NLM_BLEND_DELTA_CLAMP_EN.
//   When defined, the module has a max_delta_i port and an extra stage S0.
//   S0 clamps the denoised pixel to orig +/- max_delta_i.
//   This raises the latency from 2 cycles to 3.
module nlm_blend_out #(
    parameter int DATA_WIDTH   = 12,
    parameter int IMAGE_WIDTH  = 1920,
    parameter int IMAGE_HEIGHT = 1080,
    parameter int CNT_WIDTH    = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic                  frame_sync_i,
    input  logic                  line_sync_i,
    input  logic [DATA_WIDTH-1:0] pix_original_i,
    input  logic [DATA_WIDTH-1:0] pix_denoise_i,
`ifdef NLM_BLEND_DELTA_CLAMP_EN
    input  logic [DATA_WIDTH-1:0] max_delta_i,
`endif
    input  logic [4:0]            alpha_i,
    output logic [DATA_WIDTH-1:0] pix_o,
    output logic                  valid_o,
    output logic                  line_sync_o,
    output logic                  frame_sync_o,
    output logic                  geom_err_o
);

    localparam int PW = DATA_WIDTH + 5;
    localparam int SW = DATA_WIDTH + 6;
    localparam logic [CNT_WIDTH-1:0] W_C   = CNT_WIDTH'(IMAGE_WIDTH);
    localparam logic [CNT_WIDTH-1:0] H_C   = CNT_WIDTH'(IMAGE_HEIGHT);
    localparam logic [CNT_WIDTH-1:0] ONE_C = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Alpha above 16 would make the (16 - a) weight wrap, so it is limited to 16.
    function automatic logic [4:0] clamp_alpha(input logic [4:0] a);
        if (a > 5'd16) begin
            return 5'd16;
        end else begin
            return a;
        end
    endfunction

    // Counters stick at all-ones instead of wrapping, so a runaway line or frame stays detectable.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (v == {CNT_WIDTH{1'b1}}) begin
            return v;
        end else begin
            return v + ONE_C;
        end
    endfunction

`ifdef NLM_BLEND_DELTA_CLAMP_EN
    // Limits den to the range [orig - delta, orig + delta].
    // Both bounds are saturated to the range of the pixel.
    function automatic logic [DATA_WIDTH-1:0] clamp_delta(input logic [DATA_WIDTH-1:0] orig,
                                                          input logic [DATA_WIDTH-1:0] den,
                                                          input logic [DATA_WIDTH-1:0] delta);
        logic [DATA_WIDTH:0]   hi_ext;
        logic [DATA_WIDTH-1:0] lo;
        logic [DATA_WIDTH-1:0] hi;
        hi_ext = {1'b0, orig} + {1'b0, delta};
        if (hi_ext[DATA_WIDTH]) begin
            hi = {DATA_WIDTH{1'b1}};
        end else begin
            hi = hi_ext[DATA_WIDTH-1:0];
        end
        if (orig > delta) begin
            lo = orig - delta;
        end else begin
            lo = {DATA_WIDTH{1'b0}};
        end
        if (den < lo) begin
            return lo;
        end else if (den > hi) begin
            return hi;
        end else begin
            return den;
        end
    endfunction
`endif

    logic [4:0]            alpha_act_q;
    logic [4:0]            alpha_in_s;
    logic                  s1_en_s;
    logic                  s1_ls_s;
    logic                  s1_fs_s;
    logic [DATA_WIDTH-1:0] s1_orig_s;
    logic [DATA_WIDTH-1:0] s1_den_s;
    logic [4:0]            s1_alpha_s;
    logic [PW-1:0]         p_o_q;
    logic [PW-1:0]         p_d_q;
    logic                  v1_q;
    logic                  ls1_q;
    logic                  fs1_q;
    logic [SW-1:0]         sum_s;
    logic [DATA_WIDTH-1:0] pix_q;
    logic                  valid_q;
    logic                  ls_q;
    logic                  fs_q;
    logic [CNT_WIDTH-1:0]  col_q;
    logic [CNT_WIDTH-1:0]  col_d;
    logic [CNT_WIDTH-1:0]  row_q;
    logic [CNT_WIDTH-1:0]  row_d;
    logic                  err_q;
    logic                  err_d;
    logic                  first_q;
    logic                  first_d;

    // The frame-start pixel uses the freshly loaded alpha; every other pixel uses the shadow.
    always_comb begin
        alpha_in_s = alpha_act_q;
        if (valid_i && frame_sync_i) begin
            alpha_in_s = clamp_alpha(alpha_i);
        end else begin
            alpha_in_s = alpha_act_q;
        end
    end

    // Shadow alpha: it changes only at a valid frame start, so one frame never mixes strengths.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alpha_act_q <= 5'd16;
        end else if (valid_i && frame_sync_i) begin
            alpha_act_q <= clamp_alpha(alpha_i);
        end else begin
            alpha_act_q <= alpha_act_q;
        end
    end

`ifdef NLM_BLEND_DELTA_CLAMP_EN
    logic                  v0_q;
    logic                  ls0_q;
    logic                  fs0_q;
    logic [DATA_WIDTH-1:0] orig0_q;
    logic [DATA_WIDTH-1:0] den0_q;
    logic [4:0]            alpha0_q;

    // S0: clamps den around orig.
    // Alpha travels along because it was already resolved at the input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_q     <= 1'b0;
            ls0_q    <= 1'b0;
            fs0_q    <= 1'b0;
            orig0_q  <= {DATA_WIDTH{1'b0}};
            den0_q   <= {DATA_WIDTH{1'b0}};
            alpha0_q <= 5'd16;
        end else begin
            v0_q  <= valid_i;
            ls0_q <= line_sync_i & valid_i;
            fs0_q <= frame_sync_i & valid_i;
            if (valid_i) begin
                orig0_q  <= pix_original_i;
                den0_q   <= clamp_delta(pix_original_i, pix_denoise_i, max_delta_i);
                alpha0_q <= alpha_in_s;
            end else begin
                orig0_q  <= orig0_q;
                den0_q   <= den0_q;
                alpha0_q <= alpha0_q;
            end
        end
    end

    // S1 is fed by the clamp stage.
    always_comb begin
        s1_en_s    = v0_q;
        s1_ls_s    = ls0_q;
        s1_fs_s    = fs0_q;
        s1_orig_s  = orig0_q;
        s1_den_s   = den0_q;
        s1_alpha_s = alpha0_q;
    end
`else
    // S1 is fed directly by the ports; syncs count only together with valid.
    always_comb begin
        s1_en_s    = valid_i;
        s1_ls_s    = line_sync_i & valid_i;
        s1_fs_s    = frame_sync_i & valid_i;
        s1_orig_s  = pix_original_i;
        s1_den_s   = pix_denoise_i;
        s1_alpha_s = alpha_in_s;
    end
`endif

    // S1: weighted products.
    // Data holds during bubbles; the valid and sync flags always advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            ls1_q <= 1'b0;
            fs1_q <= 1'b0;
            p_o_q <= {PW{1'b0}};
            p_d_q <= {PW{1'b0}};
        end else begin
            v1_q  <= s1_en_s;
            ls1_q <= s1_ls_s;
            fs1_q <= s1_fs_s;
            if (s1_en_s) begin
                p_o_q <= PW'(s1_orig_s) * PW'(5'd16 - s1_alpha_s);
                p_d_q <= PW'(s1_den_s) * PW'(s1_alpha_s);
            end else begin
                p_o_q <= p_o_q;
                p_d_q <= p_d_q;
            end
        end
    end

    // Round to nearest.
    // The weights sum to 16, so the shifted result always fits in DATA_WIDTH bits.
    always_comb begin
        sum_s = SW'(p_o_q) + SW'(p_d_q) + SW'(8);
    end

    // S2: registered outputs; pix_o holds its last value across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            pix_q   <= {DATA_WIDTH{1'b0}};
        end else begin
            valid_q <= v1_q;
            ls_q    <= ls1_q;
            fs_q    <= fs1_q;
            if (v1_q) begin
                pix_q <= DATA_WIDTH'(sum_s >> 4);
            end else begin
                pix_q <= pix_q;
            end
        end
    end

    // Geometry next state.
    // Line and frame length are checked when the next sync arrives.
    // No check is made before the first frame start after reset.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        err_d   = err_q;
        first_d = first_q;
        if (valid_i) begin
            if (frame_sync_i) begin
                if (!first_q && ((row_q != H_C) || (col_q != W_C))) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                first_d = 1'b0;
                col_d   = ONE_C;
                row_d   = ONE_C;
            end else if (line_sync_i) begin
                if (!first_q && (col_q != W_C)) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                col_d = ONE_C;
                row_d = sat_inc(row_q);
            end else begin
                col_d = sat_inc(col_q);
            end
        end else begin
            col_d = col_q;
        end
    end

    // Geometry state; the error flag is sticky until the next reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= {CNT_WIDTH{1'b0}};
            row_q   <= {CNT_WIDTH{1'b0}};
            err_q   <= 1'b0;
            first_q <= 1'b1;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    assign pix_o        = pix_q;
    assign valid_o      = valid_q;
    assign line_sync_o  = ls_q;
    assign frame_sync_o = fs_q;
    assign geom_err_o   = err_q;

endmodule
